mining_result_tx: RTL and testbench

MINING_RESULT_TX -- requirements
Module: mining_result_tx

---
 rtl/mining_result_tx_pkg.sv | 31 +++
 rtl/mining_result_tx_xor.sv | 16 +
 rtl/mining_result_tx.sv | 130 +++++++++++++
 tb/tb_mining_result_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_result_tx_pkg.sv
// Shared types and constants for the mining result frame transmitter.
package mining_result_tx_pkg;

    localparam int unsigned WordW            = 32;
    localparam int unsigned PayloadWords     = 10;
    localparam int unsigned FrameWordsNoCsum = 10;
    localparam int unsigned FrameWordsCsum   = 11;

    typedef logic [WordW-1:0] word_t;
    typedef logic [PayloadWords-1:0][WordW-1:0] payload_t;

    typedef struct packed {
        word_t        block;
        logic [255:0] hash;
        word_t        nonce;
    } result_t;

    typedef enum logic {StIdle, StSend} state_e;

    // Frame order: block, hash from the most significant word down, nonce.
    function automatic payload_t to_payload(result_t r);
        payload_t p;
        p[0] = r.block;
        for (int i = 0; i < 8; i++) begin
            p[i+1] = r.hash[255-32*i -: 32];
        end
        p[9] = r.nonce;
        return p;
    endfunction

endpackage

// File: rtl/mining_result_tx_xor.sv
// Combinational XOR checksum over the ten payload words of a result frame.
module result_frame_xor
    import mining_result_tx_pkg::*;
(
    input  payload_t words,
    output word_t    checksum
);

    always_comb begin
        checksum = '0;
        for (int i = 0; i < PayloadWords; i++) begin
            checksum = checksum ^ words[i];
        end
    end

endmodule

// File: rtl/mining_result_tx.sv
// Serialises miner results into 32-bit frames with one pending slot and a
// saturating counter of results dropped for lack of buffer space.
module mining_result_tx
    import mining_result_tx_pkg::*;
#(
    parameter bit          CHECKSUM_EN = 1'b1,
    parameter int unsigned DROP_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    input  logic [255:0]          res_hash,
    input  logic [31:0]           res_nonce,
    input  logic [31:0]           res_block,
    output logic [31:0]           tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_last,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [3:0] LastIdx = CHECKSUM_EN ? 4'd10 : 4'd9;

    state_e                  state_q, state_d;
    logic [3:0]              idx_q, idx_d;
    result_t                 act_q, act_d;
    result_t                 pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;

    result_t  res_in;
    payload_t act_words;
    word_t    csum;
    logic     hs, final_hs;

    assign res_in    = '{block: res_block, hash: res_hash, nonce: res_nonce};
    assign act_words = to_payload(act_q);

    result_frame_xor u_xor (
        .words    (act_words),
        .checksum (csum)
    );

    assign hs       = (state_q == StSend) && tx_ready;
    assign final_hs = hs && (idx_q == LastIdx);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        drop_d      = drop_q;
        unique case (state_q)
            StIdle: begin
                if (res_valid) begin
                    act_d   = res_in;
                    idx_d   = 4'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (final_hs) begin
                    idx_d = 4'd0;
                    if (pend_full_q) begin
                        // Pending slot advances; a coincident result refills it.
                        act_d = pend_q;
                        if (res_valid) begin
                            pend_d = res_in;
                        end else begin
                            pend_full_d = 1'b0;
                        end
                    end else if (res_valid) begin
                        act_d = res_in;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (hs) begin
                        idx_d = idx_q + 4'd1;
                    end
                    if (res_valid) begin
                        if (!pend_full_q) begin
                            pend_d      = res_in;
                            pend_full_d = 1'b1;
                        end else if (drop_q != '1) begin
                            drop_d = drop_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        tx_valid = (state_q == StSend);
        tx_last  = tx_valid && (idx_q == LastIdx);
        tx_data  = '0;
        if (tx_valid) begin
            if (idx_q < 4'd10) begin
                tx_data = act_words[idx_q];
            end else begin
                tx_data = csum;
            end
        end
        busy       = tx_valid || pend_full_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_mining_result_tx.sv
// Self-checking bench: vector table plus scoreboarded multi-cycle sequences.
module tb_mining_result_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         res_valid, res_valid0;
    logic [255:0] res_hash;
    logic [31:0]  res_nonce, res_block;
    logic [31:0]  tx_data, tx_data0;
    logic         tx_valid, tx_valid0, tx_ready, tx_ready0, tx_last, tx_last0;
    logic         busy, busy0;
    logic [7:0]   drop_count, drop_count0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp0_q[$];

    typedef struct {
        logic [31:0]  block;
        logic [255:0] hash;
        logic [31:0]  nonce;
        logic [31:0]  csum;
        bit           stall;
    } vec_t;

    vec_t vecs[5];

    mining_result_tx #(.CHECKSUM_EN(1'b1), .DROP_CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_hash   (res_hash),
        .res_nonce  (res_nonce),
        .res_block  (res_block),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_last    (tx_last),
        .busy       (busy),
        .drop_count (drop_count)
    );

    mining_result_tx #(.CHECKSUM_EN(1'b0), .DROP_CNT_W(8)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid0),
        .res_hash   (res_hash),
        .res_nonce  (res_nonce),
        .res_block  (res_block),
        .tx_data    (tx_data0),
        .tx_valid   (tx_valid0),
        .tx_ready   (tx_ready0),
        .tx_last    (tx_last0),
        .busy       (busy0),
        .drop_count (drop_count0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] b, input logic [255:0] h, input logic [31:0] n,
                              input bit use_csum, input logic [31:0] csum_given, input bit to_dut0);
        logic [31:0] w[11];
        logic [31:0] x;
        int cnt;
        w[0] = b;
        for (int i = 0; i < 8; i++) w[i+1] = h[255-32*i -: 32];
        w[9] = n;
        x = 32'h0;
        for (int i = 0; i < 10; i++) x = x ^ w[i];
        w[10] = use_csum ? csum_given : x;
        cnt = to_dut0 ? 10 : 11;
        for (int i = 0; i < cnt; i++) begin
            if (to_dut0) exp0_q.push_back('{data: w[i], last: (i == cnt - 1)});
            else         exp_q.push_back('{data: w[i], last: (i == cnt - 1)});
        end
    endtask

    task automatic drive(input logic [31:0] b, input logic [255:0] h, input logic [31:0] n);
        res_block = b;
        res_hash  = h;
        res_nonce = n;
    endtask

    task automatic pulse(input logic [31:0] b, input logic [255:0] h, input logic [31:0] n);
        drive(b, h, n);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic drain(input int budget, input bit toggle, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (toggle) tx_ready = (n % 4 == 0) || (n % 4 == 3);
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        tx_ready = 1'b1;
    endtask

    task automatic wait_last(input int budget);
        int n = 0;
        while (!(tx_valid && tx_last) && n < budget) begin
            tick();
            n++;
        end
        check("wait_final_word", tx_valid && tx_last, 1);
    endtask

    // Main DUT monitor: scoreboard pops on handshake, stall stability check.
    bit          stall_q = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    exp_t        mon_e, mon0_e;

    always @(negedge clk) begin
        if (stall_q) begin
            check("stall_valid", tx_valid, 1);
            check("stall_data", tx_data, held_data);
            check("stall_last", tx_last, held_last);
        end
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("word_data", tx_data, mon_e.data);
                check("word_last", tx_last, mon_e.last);
            end
        end
        stall_q   = rst && tx_valid && !tx_ready;
        held_data = tx_data;
        held_last = tx_last;
    end

    always @(negedge clk) begin
        if (tx_valid0 && tx_ready0) begin
            if (exp0_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word0: got %0h expected none", tx_data0);
            end else begin
                mon0_e = exp0_q.pop_front();
                check("word0_data", tx_data0, mon0_e.data);
                check("word0_last", tx_last0, mon0_e.last);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] drops_before;
        int gaps;
        int n;

        vecs[0] = '{32'h00000007, {8'hFF, 240'd0, 8'h01}, 32'h1234ABCD, 32'hED34ABCB, 1'b0};
        vecs[1] = '{32'h0, 256'd0, 32'h0, 32'h0, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, {256{1'b1}}, 32'h0, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{32'h11111111, {8{32'h22222222}}, 32'h44444444, 32'h55555555, 1'b1};
        vecs[4] = '{32'hA5A5A5A5, {32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80},
                    32'h5A5A5A5A, 32'hFFFFFF00, 1'b0};

        rst        = 1'b0;
        res_valid  = 1'b0;
        res_valid0 = 1'b0;
        tx_ready   = 1'b1;
        tx_ready0  = 1'b0;
        drive(32'h0, 256'd0, 32'h0);
        repeat (3) tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        check("rst_tx_valid0", tx_valid0, 0);
        rst = 1'b1;
        tick();

        // Vector table: single frames, with and without 1,0,0,1 backpressure.
        for (int v = 0; v < 5; v++) begin
            tx_ready = 1'b1;
            check("idle_before_pulse", tx_valid, 0);
            push_frame(vecs[v].block, vecs[v].hash, vecs[v].nonce, 1'b1, vecs[v].csum, 1'b0);
            if (vecs[v].stall) tx_ready = 1'b1;
            pulse(vecs[v].block, vecs[v].hash, vecs[v].nonce);
            check("latency_valid", tx_valid, 1);
            check("latency_busy", busy, 1);
            drain(200, vecs[v].stall, "table_drain");
            tick();
            check("table_idle_after", tx_valid, 0);
            check("table_busy_after", busy, 0);
        end

        // Active, pending, dropped; then back-to-back release.
        tx_ready = 1'b0;
        push_frame(32'hB1, {8{32'h11}}, 32'hC1, 1'b0, 32'h0, 1'b0);
        pulse(32'hB1, {8{32'h11}}, 32'hC1);
        tick();
        push_frame(32'hB2, {8{32'h22}}, 32'hC2, 1'b0, 32'h0, 1'b0);
        pulse(32'hB2, {8{32'h22}}, 32'hC2);
        tick();
        pulse(32'hB3, {8{32'h33}}, 32'hC3);
        check("three_drop_count", drop_count, 1);
        check("three_busy", busy, 1);
        tx_ready = 1'b1;
        gaps = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            if (!tx_valid) gaps++;
            tick();
            n++;
        end
        check("three_drained", exp_q.size(), 0);
        check("three_no_gap", gaps, 0);
        repeat (3) tick();
        check("three_third_dropped", tx_valid, 0);
        check("three_busy_after", busy, 0);

        // Result on final-word handshake with pending full.
        drops_before = drop_count;
        tx_ready = 1'b0;
        push_frame(32'hA0, {8{32'hAA}}, 32'hA9, 1'b0, 32'h0, 1'b0);
        pulse(32'hA0, {8{32'hAA}}, 32'hA9);
        push_frame(32'hB0, {8{32'hBB}}, 32'hB9, 1'b0, 32'h0, 1'b0);
        pulse(32'hB0, {8{32'hBB}}, 32'hB9);
        tx_ready = 1'b1;
        wait_last(50);
        push_frame(32'hC0, {8{32'hCC}}, 32'hC9, 1'b0, 32'h0, 1'b0);
        pulse(32'hC0, {8{32'hCC}}, 32'hC9);
        check("final_hs_valid", tx_valid, 1);
        check("final_hs_word0", tx_data, 32'hB0);
        check("final_hs_busy", busy, 1);
        check("final_hs_drop", drop_count, drops_before);
        drain(200, 1'b0, "final_hs_drain");

        // Result on final-word handshake with pending empty.
        push_frame(32'hD0, {8{32'hDD}}, 32'hD9, 1'b0, 32'h0, 1'b0);
        pulse(32'hD0, {8{32'hDD}}, 32'hD9);
        wait_last(50);
        push_frame(32'hE0, {8{32'hEE}}, 32'hE9, 1'b0, 32'h0, 1'b0);
        pulse(32'hE0, {8{32'hEE}}, 32'hE9);
        check("direct_load_valid", tx_valid, 1);
        check("direct_load_word0", tx_data, 32'hE0);
        drain(200, 1'b0, "direct_load_drain");

        // Reset at word 5 with pending full.
        push_frame(32'hF0, {32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'hF6, 32'hF7, 32'hF8},
                   32'hF9, 1'b0, 32'h0, 1'b0);
        pulse(32'hF0, {32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5, 32'hF6, 32'hF7, 32'hF8}, 32'hF9);
        pulse(32'h60, {8{32'h66}}, 32'h69);
        n = 0;
        while (!(tx_valid && tx_data == 32'hF5) && n < 30) begin
            tick();
            n++;
        end
        check("reach_word5", tx_data, 32'hF5);
        check("word5_pending_busy", busy, 1);
        rst = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_valid", tx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_drop", drop_count, 0);
        check("midrst_data", tx_data, 0);
        check("midrst_last", tx_last, 0);
        rst = 1'b1;
        repeat (4) tick();
        check("postrst_silent", tx_valid, 0);
        push_frame(32'h70, {8{32'h77}}, 32'h79, 1'b0, 32'h0, 1'b0);
        pulse(32'h70, {8{32'h77}}, 32'h79);
        check("postrst_word0", tx_data, 32'h70);
        drain(200, 1'b0, "postrst_drain");

        // No-checksum variant with saturating drop counter.
        tx_ready0 = 1'b0;
        push_frame(32'h0A, {8{32'h0B}}, 32'h0C, 1'b0, 32'h0, 1'b1);
        drive(32'h0A, {8{32'h0B}}, 32'h0C);
        res_valid0 = 1'b1;
        tick();
        push_frame(32'h1A, {8{32'h1B}}, 32'h1C, 1'b0, 32'h0, 1'b1);
        drive(32'h1A, {8{32'h1B}}, 32'h1C);
        tick();
        drive(32'h2A, {8{32'h2B}}, 32'h2C);
        repeat (100) tick();
        check("nocs_drop_100", drop_count0, 100);
        repeat (200) tick();
        res_valid0 = 1'b0;
        check("nocs_drop_sat", drop_count0, 255);
        tx_ready0 = 1'b1;
        n = 0;
        while (exp0_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("nocs_drained", exp0_q.size(), 0);
        repeat (2) tick();
        check("nocs_idle", tx_valid0, 0);
        check("nocs_drop_hold", drop_count0, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
